// File: rtl/mprj_checkpoint_monitor_pkg.sv
// Shared types and constants for the mprj check-bus checkpoint monitor.
package mprj_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
  localparam logic [1:0] FAIL_ORDER   = 2'd2;
  localparam logic [1:0] FAIL_ABORT   = 2'd3;

  // Width needed to count 0..n accepted checkpoints.
  function automatic int idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mprj_checkpoint_monitor_cdc_sync_bus.sv
// Plain flop-chain synchroniser for the asynchronous check bus; per-bit skew
// is tolerated because the consumer only acts on values held for several cycles.
module cdc_sync_bus
  import mprj_chk_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint-sequence monitor: a stability-filtered check bus must show the
// EXPECT codes in order within a global cycle budget.
module mprj_checkpoint_monitor
  import mprj_chk_pkg::*;
#(
  parameter int                     WIDTH       = 16,
  parameter int                     NUM_CP      = 2,
  parameter logic [NUM_CP*WIDTH-1:0] EXPECT     = {16'hAB61, 16'hAB60},
  parameter int                     STABLE      = 4,
  parameter int                     SYNC_STAGES = 2,
  parameter int                     TIMEOUT     = 70000,
  parameter int                     TW          = 32,
  parameter int                     STRICT      = 0
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [WIDTH-1:0]            checkbits,
  output logic                        cp_hit,
  output logic [idx_w(NUM_CP)-1:0]    cp_index,
  output logic [TW-1:0]               cycles,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic [1:0]                  fail_code
);

  localparam int              IW       = idx_w(NUM_CP);
  localparam int              CW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0]   STABLE_C = CW'(STABLE);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_CP - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  logic [WIDTH-1:0] sync;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    cyc_q, cyc_d;
  logic             hit_q, hit_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic [1:0]       code_q, code_d;

  logic stable_evt, accept, later_hit;

  cdc_sync_bus #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clock),
    .rst_ni (resetb),
    .d_i    (checkbits),
    .q_o    (sync)
  );

  function automatic logic [WIDTH-1:0] exp_code(input int i);
    if (i < 0 || i >= NUM_CP) return '0;
    return EXPECT[i*WIDTH +: WIDTH];
  endfunction

  always_comb begin
    state_d    = state_q;
    last_d     = sync;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    hit_d      = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    code_d     = code_q;
    stable_evt = 1'b0;
    accept     = 1'b0;
    later_hit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Clearing the count forces any pre-existing code to be re-held.
        if (enable && !clear) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          idx_d   = '0;
          cyc_d   = '0;
        end
      end

      ST_RUN: begin
        if (sync != last_q) begin
          cnt_d = CW'(1);
        end else if (cnt_q < STABLE_C) begin
          cnt_d = cnt_q + CW'(1);
        end
        stable_evt = (cnt_d == STABLE_C) && (cnt_q < STABLE_C);
        accept     = stable_evt && (sync == exp_code(int'(idx_q)));
        for (int j = 0; j < NUM_CP; j++) begin
          if (STRICT != 0 && stable_evt && !accept && j > int'(idx_q) &&
              sync == exp_code(j)) begin
            later_hit = 1'b1;
          end
        end
        cyc_d = cyc_q + TW'(1);

        // Abort outranks everything; a final accept outranks the timeout.
        if (!enable) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          code_d  = FAIL_ABORT;
        end else begin
          if (accept) begin
            hit_d = 1'b1;
            idx_d = idx_q + IW'(1);
          end
          if (accept && idx_q == LAST_IDX) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else if (later_hit) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = FAIL_ORDER;
          end else if (cyc_q == TMO_LAST) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = FAIL_TIMEOUT;
          end
        end
      end

      ST_PASS, ST_FAIL: begin
        if (clear) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          code_d  = FAIL_NONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    done_d = pass_d | fail_d;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      hit_q   <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= FAIL_NONE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      hit_q   <= hit_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign cp_hit    = hit_q;
  assign cp_index  = idx_q;
  assign cycles    = cyc_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;

endmodule
